// File: rtl/cam_downsampler.sv
// cam_downsampler
//   Capture stage between the OV7670 byte stream and the frame buffer.
//   Pairs RGB565 bytes (two per pixel, qualified by HREF/VSYNC), converts
//   each pixel to RGB332 and issues one frame-buffer write per pixel with a
//   linear address Y*SCREEN_WIDTH+X. Reports end-of-frame on VSYNC rise.
//
// Build option:
//   COLOR_BAR_TEST_EN - pixel data is replaced by three 48-line colour bars
//                       (E0 / 1C / 03); addressing and timing are unchanged.
//
// Ports:
//   i_clk          camera pixel clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_cam_data     camera byte bus
//   i_cam_href     line-valid qualifier
//   i_cam_vsync    vertical blanking (high = blanking)
//   o_pixel        RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//   o_w_addr       frame-buffer write address
//   o_w_en         one-cycle write strobe
//   o_x_addr       column of the last written pixel
//   o_y_addr       line of the current pixel
//   o_frame_done   one-cycle pulse on VSYNC rising edge
module cam_downsampler #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_cam_data,
  input  logic        i_cam_href,
  input  logic        i_cam_vsync,
  output logic [7:0]  o_pixel,
  output logic [14:0] o_w_addr,
  output logic        o_w_en,
  output logic [7:0]  o_x_addr,
  output logic [7:0]  o_y_addr,
  output logic        o_frame_done
);

  localparam logic [7:0]  LP_W   = 8'(SCREEN_WIDTH);
  localparam logic [7:0]  LP_H   = 8'(SCREEN_HEIGHT);
  localparam logic [14:0] LP_W15 = 15'(SCREEN_WIDTH);

  logic        r_phase;
  logic [7:0]  r_byte0;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [14:0] r_base;
  logic        r_href_d;
  logic        r_vsync_d;

  logic [7:0]  w_pixel;
  logic        w_in_frame;

`ifdef COLOR_BAR_TEST_EN
  always_comb begin
    if (r_y < 8'd48)
      w_pixel = 8'hE0;
    else if (r_y < 8'd96)
      w_pixel = 8'h1C;
    else
      w_pixel = 8'h03;
  end
`else
  // byte0 = R[4:0],G[5:3]; byte1 = G[2:0],B[4:0] -> keep the top bits of each
  assign w_pixel = {r_byte0[7:5], r_byte0[2:0], i_cam_data[4:3]};
`endif

  // X and Y both saturate at the frame size, so this also blocks writes
  // for over-long lines and for lines past the last one
  assign w_in_frame = (r_x < LP_W) && (r_y < LP_H);

  assign o_y_addr = r_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase      <= 1'b0;
      r_byte0      <= 8'd0;
      r_x          <= 8'd0;
      r_y          <= 8'd0;
      r_base       <= 15'd0;
      r_href_d     <= 1'b0;
      r_vsync_d    <= 1'b0;
      o_pixel      <= 8'd0;
      o_w_addr     <= 15'd0;
      o_w_en       <= 1'b0;
      o_x_addr     <= 8'd0;
      o_frame_done <= 1'b0;
    end else begin
      r_href_d     <= i_cam_href;
      r_vsync_d    <= i_cam_vsync;
      o_frame_done <= i_cam_vsync & ~r_vsync_d;
      o_w_en       <= 1'b0;

      if (i_cam_vsync) begin
        // blanking overrides any HREF activity, including a coincident fall
        r_phase  <= 1'b0;
        r_x      <= 8'd0;
        r_y      <= 8'd0;
        r_base   <= 15'd0;
        o_x_addr <= 8'd0;
      end else if (i_cam_href) begin
        if (!r_phase) begin
          r_byte0 <= i_cam_data;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (w_in_frame) begin
            o_w_en   <= 1'b1;
            o_pixel  <= w_pixel;
            o_w_addr <= r_base + {7'd0, r_x};
            o_x_addr <= r_x;
            r_x      <= r_x + 8'd1;
          end
        end
      end else begin
        // a dangling odd byte is dropped when the line ends
        r_phase <= 1'b0;
        // X is only non-zero if something was written, which implies Y is
        // still below the frame height, so Y saturates without a compare
        if (r_href_d && (r_x != 8'd0)) begin
          r_y    <= r_y + 8'd1;
          r_base <= r_base + LP_W15;
          r_x    <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_downsampler.sv
module tb_cam_downsampler;
  localparam int W = 176;
  localparam int H = 144;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        href = 1'b0;
  logic        vsync = 1'b0;
  logic [7:0]  pixel;
  logic [14:0] w_addr;
  logic        w_en;
  logic [7:0]  x_addr;
  logic [7:0]  y_addr;
  logic        frame_done;

  always #5 clk = ~clk;

  cam_downsampler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cam_data(cam_data),
    .i_cam_href(href), .i_cam_vsync(vsync),
    .o_pixel(pixel), .o_w_addr(w_addr), .o_w_en(w_en),
    .o_x_addr(x_addr), .o_y_addr(y_addr), .o_frame_done(frame_done)
  );

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
    logic [7:0]  x;
    logic [7:0]  y;
  } wr_t;

  wr_t        cap_q[$];
  wr_t        exp_q[$];
  int         cap_cyc[$];
  logic [7:0] byte_q[$];
  int checks = 0;
  int errors = 0;
  int m_y = 0;
  int b2b = 0;
  int fd_cnt = 0;
  int cyc = 0;
  logic prev_wen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (w_en) begin
      cap_q.push_back({w_addr, pixel, x_addr, y_addr});
      cap_cyc.push_back(cyc);
      if (prev_wen) b2b++;
    end
    prev_wen = w_en;
    if (frame_done) fd_cnt++;
  end

  // RGB565 -> RGB332 by truncating each channel to its top bits
  function automatic logic [7:0] model_pixel(input int b0, input int b1, input int y);
    int r, g, b;
`ifdef COLOR_BAR_TEST_EN
    r = b0; g = b1;
    if (y < 48) return 8'hE0;
    if (y < 96) return 8'h1C;
    return 8'h03;
`else
    r = b0 >> 3;
    g = ((b0 & 7) << 3) | (b1 >> 5);
    b = b1 & 31;
    return 8'(((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3));
`endif
  endfunction

  task automatic clear_q();
    cap_q.delete(); exp_q.delete(); cap_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; href = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_y = 0;
    @(negedge clk);
  endtask

  task automatic fill_random(input int n);
    byte_q.delete();
    repeat (n) byte_q.push_back(8'($urandom));
  endtask

  // Frame model: each line of n bytes yields n/2 pixels; the first W of them
  // land on line m_y if it is inside the frame, and only non-empty lines count.
  task automatic drive_line(input int gap);
    int npix;
    wr_t e;
    npix = byte_q.size() / 2;
    if (npix > 0 && m_y < H) begin
      for (int x = 0; x < npix && x < W; x++) begin
        e.addr = 15'(m_y * W + x);
        e.data = model_pixel(int'(byte_q[2*x]), int'(byte_q[2*x+1]), m_y);
        e.x = 8'(x);
        e.y = 8'(m_y);
        exp_q.push_back(e);
      end
      m_y++;
    end
    foreach (byte_q[i]) begin
      @(negedge clk);
      href = 1'b1;
      cam_data = byte_q[i];
    end
    @(negedge clk);
    href = 1'b0;
    cam_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (pixel !== 8'd0)       begin errors++; $display("FAIL reset_pixel got %h exp 00", pixel); end
    checks++; if (w_addr !== 15'd0)     begin errors++; $display("FAIL reset_w_addr got %0d exp 0", w_addr); end
    checks++; if (w_en !== 1'b0)        begin errors++; $display("FAIL reset_w_en got %b exp 0", w_en); end
    checks++; if (x_addr !== 8'd0)      begin errors++; $display("FAIL reset_x_addr got %0d exp 0", x_addr); end
    checks++; if (y_addr !== 8'd0)      begin errors++; $display("FAIL reset_y_addr got %0d exp 0", y_addr); end
    checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    rst_n = 1'b1;
    m_y = 0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [7:0] exp_d[4];
    exp_d[0] = 8'hE0; exp_d[1] = 8'h1C; exp_d[2] = 8'h03; exp_d[3] = 8'hFF;
    do_reset(); clear_q(); b2b = 0;
    byte_q.delete();
    byte_q = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    drive_line(3);
    checks++; if (cap_q.size() !== 4) begin errors++; $display("FAIL vec_count got %0d exp 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i].addr !== 15'(i) || cap_q[i].data !== exp_d[i]) begin
        errors++; $display("FAIL vec_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, cap_q[i].addr, cap_q[i].data, i, exp_d[i]);
      end
      if (i > 0) begin
        checks++;
        if (cap_cyc[i] - cap_cyc[i-1] !== 2) begin
          errors++; $display("FAIL vec_spacing[%0d] got %0d exp 2", i, cap_cyc[i] - cap_cyc[i-1]);
        end
      end
    end
    checks++; if (b2b !== 0) begin errors++; $display("FAIL vec_back_to_back got %0d exp 0", b2b); end
  endtask

  task automatic test_two_lines();
    do_reset(); clear_q();
    fill_random(6); drive_line(4);
    fill_random(6); drive_line(2);
    checks++; if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL two_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, cap_q[i].addr, cap_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
    checks++; if (cap_q.size() > 3 && cap_q[3].addr !== 15'd176) begin errors++; $display("FAIL two_line2_addr got %0d exp 176", cap_q[3].addr); end
    checks++; if (y_addr !== 8'd2) begin errors++; $display("FAIL two_y_after got %0d exp 2", y_addr); end
  endtask

  task automatic test_long_line();
    do_reset(); clear_q();
    fill_random(400); drive_line(2);
    fill_random(6); drive_line(2);
    checks++; if (cap_q.size() !== 179) begin errors++; $display("FAIL long_count got %0d exp 179", cap_q.size()); end
    checks++; if (cap_q.size() > 176 && (cap_q[175].addr !== 15'd175 || cap_q[176].addr !== 15'd176)) begin
      errors++; $display("FAIL long_edge got last=%0d next=%0d exp 175 176", cap_q[175].addr, cap_q[176].addr);
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL long_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, cap_q[i].addr, cap_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_odd_bytes();
    do_reset(); clear_q();
    fill_random(5); drive_line(3);
    fill_random(4); drive_line(2);
    checks++; if (cap_q.size() !== 4) begin errors++; $display("FAIL odd_count got %0d exp 4", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL odd_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, cap_q[i].addr, cap_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_vsync_midline();
    int fd0;
    wr_t e;
    do_reset(); clear_q();
    fill_random(5);
    for (int x = 0; x < 2; x++) begin
      e.addr = 15'(x); e.data = model_pixel(int'(byte_q[2*x]), int'(byte_q[2*x+1]), 0);
      e.x = 8'(x); e.y = 8'd0;
      exp_q.push_back(e);
    end
    foreach (byte_q[i]) begin @(negedge clk); href = 1'b1; cam_data = byte_q[i]; end
    fd0 = fd_cnt;
    @(negedge clk); vsync = 1'b1; cam_data = 8'($urandom);
    repeat (6) begin @(negedge clk); cam_data = 8'($urandom); end
    vsync = 1'b0; href = 1'b0;
    repeat (3) @(negedge clk);
    m_y = 0;
    checks++; if (cap_q.size() !== 2) begin errors++; $display("FAIL vs_writes_during got %0d exp 2", cap_q.size()); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL vs_frame_done_cycles got %0d exp 1", fd_cnt - fd0); end
    fill_random(4); drive_line(2);
    checks++; if (cap_q.size() > 2 && cap_q[2].addr !== 15'd0) begin errors++; $display("FAIL vs_next_addr got %0d exp 0", cap_q[2].addr); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL vs_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, cap_q[i].addr, cap_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_reset_midline();
    do_reset(); clear_q();
    fill_random(6); drive_line(2);
    fill_random(6); drive_line(2);
    @(negedge clk); href = 1'b1; cam_data = 8'($urandom);
    @(negedge clk); cam_data = 8'($urandom);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pixel !== 8'd0)   begin errors++; $display("FAIL rm_pixel got %h exp 00", pixel); end
    checks++; if (w_addr !== 15'd0) begin errors++; $display("FAIL rm_w_addr got %0d exp 0", w_addr); end
    checks++; if (y_addr !== 8'd0 || x_addr !== 8'd0) begin errors++; $display("FAIL rm_xy got %0d,%0d exp 0,0", x_addr, y_addr); end
    href = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_y = 0;
    @(negedge clk);
    clear_q();
    fill_random(6); drive_line(2);
    checks++; if (cap_q.size() !== 3) begin errors++; $display("FAIL rm_count got %0d exp 3", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL rm_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, cap_q[i].addr, cap_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_saturation();
    do_reset(); clear_q();
    repeat (H + 2) begin fill_random(2); drive_line(0); end
    fill_random(4); drive_line(2);
    checks++; if (cap_q.size() !== H) begin errors++; $display("FAIL sat_count got %0d exp %0d", cap_q.size(), H); end
    checks++; if (y_addr !== 8'(H)) begin errors++; $display("FAIL sat_y got %0d exp %0d", y_addr, H); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, cap_q[i].addr, cap_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_random();
    do_reset(); clear_q(); b2b = 0;
    for (int l = 0; l < 20; l++) begin
      if ($urandom_range(0, 4) == 0) fill_random(int'($urandom_range(350, 372)));
      else fill_random(int'($urandom_range(0, 41)));
      drive_line(int'($urandom_range(0, 5)));
    end
    repeat (2) @(negedge clk);
    checks++; if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_wr[%0d] got addr=%0d data=%h y=%0d exp addr=%0d data=%h y=%0d", i, cap_q[i].addr, cap_q[i].data, cap_q[i].y, exp_q[i].addr, exp_q[i].data, exp_q[i].y); end
    end
    checks++; if (b2b !== 0) begin errors++; $display("FAIL rnd_back_to_back got %0d exp 0", b2b); end
  endtask

`ifdef COLOR_BAR_TEST_EN
  task automatic test_colorbar();
    do_reset(); clear_q();
    repeat (H) begin fill_random(2 * W); drive_line(1); end
    checks++; if (cap_q.size() !== 25344) begin errors++; $display("FAIL cb_count got %0d exp 25344", cap_q.size()); end
    if (cap_q.size() == 25344) begin
      checks++; if (cap_q[0].data !== 8'hE0)     begin errors++; $display("FAIL cb_0 got %h exp E0", cap_q[0].data); end
      checks++; if (cap_q[8448].data !== 8'h1C)  begin errors++; $display("FAIL cb_8448 got %h exp 1C", cap_q[8448].data); end
      checks++; if (cap_q[16896].data !== 8'h03) begin errors++; $display("FAIL cb_16896 got %h exp 03", cap_q[16896].data); end
      checks++; if (cap_q[25343].addr !== 15'd25343 || cap_q[25343].data !== 8'h03) begin
        errors++; $display("FAIL cb_last got addr=%0d data=%h exp 25343 03", cap_q[25343].addr, cap_q[25343].data);
      end
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      if (cap_q[i] !== exp_q[i]) begin
        checks++; errors++;
        $display("FAIL cb_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, cap_q[i].addr, cap_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_two_lines();
    test_long_line();
    test_odd_bytes();
    test_vsync_midline();
    test_reset_midline();
    test_saturation();
    test_random();
`ifdef COLOR_BAR_TEST_EN
    test_colorbar();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
